// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
// Optional misaligned-fetch trap: IFETCH_ADEL_EN.
package inst_fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ADDR,
    S_WAIT_DATA,
    S_HOLD,
    S_DISCARD_A,
    S_DISCARD_D
  } fetch_state_e;

  localparam logic STOP        = 1'b1;
  localparam logic NOSTOP      = 1'b0;
  localparam logic CHIP_ENABLE = 1'b1;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC00000;
  localparam logic [31:0] NOP_INST_DEF = 32'h00000000;

endpackage

// File: rtl/inst_fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register: flush > bubble > hold > load > bubble.
// Carries the address-error flag when IFETCH_ADEL_EN is defined.
module if_id_reg
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        ld,
  input  logic [31:0] ld_pc,
  input  logic [31:0] ld_inst,
`ifdef IFETCH_ADEL_EN
  input  logic        ld_adel,
  output logic        id_excp_adel,
`endif
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  logic do_flush;
  logic do_bub;
  logic do_hold;
  logic do_ld;

  assign do_flush = flush;
  assign do_bub   = !flush && (stall_if == STOP)
                  && (stall_id == NOSTOP);
  assign do_hold  = !flush && (stall_if == STOP)
                  && (stall_id == STOP);
  assign do_ld    = !flush && (stall_if == NOSTOP) && ld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc        <= RESET_PC;
      id_inst      <= NOP_INST;
      id_valid     <= 1'b0;
`ifdef IFETCH_ADEL_EN
      id_excp_adel <= 1'b0;
`endif
    end else begin
      unique case (1'b1)
        do_hold: ;
        do_ld: begin
          id_pc        <= ld_pc;
          id_inst      <= ld_inst;
          id_valid     <= 1'b1;
`ifdef IFETCH_ADEL_EN
          id_excp_adel <= ld_adel;
`endif
        end
        do_flush, do_bub: begin
          id_inst      <= NOP_INST;
          id_valid     <= 1'b0;
`ifdef IFETCH_ADEL_EN
          id_excp_adel <= 1'b0;
`endif
        end
        default: begin
          id_inst      <= NOP_INST;
          id_valid     <= 1'b0;
`ifdef IFETCH_ADEL_EN
          id_excp_adel <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch FSM over an SRAM-like bus, with hold buffer.
// IFETCH_ADEL_EN traps misaligned pc instead of fetching it.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        ce,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic        stallreq_if,
`ifdef IFETCH_ADEL_EN
  output logic        id_excp_adel,
`endif
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  fetch_state_e state_q;
  logic         req_q;
  logic [31:0]  addr_q;
  logic [31:0]  buf_q;

  logic        s_if;
  logic        misal;
  logic        data_done;
  logic        adel_ld;
  logic        ld;
  logic [31:0] ld_pc;
  logic [31:0] ld_inst;
  logic        unused_stall;

  assign unused_stall = ^{stall[5:3], stall[0]};
  assign s_if = (stall[1] == STOP);

`ifdef IFETCH_ADEL_EN
  assign misal = (ce == CHIP_ENABLE)
              && (pc[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  assign data_done = inst_data_ok && !flush
    && ((state_q == S_WAIT_DATA)
     || (state_q == S_WAIT_ADDR && inst_addr_ok));
  assign adel_ld = (state_q == S_IDLE) && misal;
  assign ld = (data_done && !s_if)
           || (state_q == S_HOLD) || adel_ld;
  assign ld_pc = adel_ld ? pc : addr_q;
  assign ld_inst = (state_q == S_HOLD) ? buf_q
                 : adel_ld ? NOP_INST : inst_rdata;

  assign inst_req  = req_q;
  assign inst_addr = addr_q;

  always_comb begin
    stallreq_if = 1'b0;
    if (rst) begin
      unique case (state_q)
        S_IDLE:
          stallreq_if = (ce == CHIP_ENABLE) && !misal;
        S_WAIT_ADDR:
          stallreq_if = !(inst_addr_ok && inst_data_ok);
        S_WAIT_DATA: stallreq_if = !inst_data_ok;
        S_HOLD:      stallreq_if = 1'b0;
        S_DISCARD_A: stallreq_if = 1'b1;
        S_DISCARD_D: stallreq_if = 1'b1;
        default:     stallreq_if = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      buf_q   <= NOP_INST;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ce == CHIP_ENABLE && !flush && !misal) begin
            req_q   <= 1'b1;
            addr_q  <= pc;
            state_q <= S_WAIT_ADDR;
          end
        end
        S_WAIT_ADDR: begin
          if (inst_addr_ok) begin
            req_q <= 1'b0;
            if (inst_data_ok) begin
              if (!flush && s_if) begin
                buf_q   <= inst_rdata;
                state_q <= S_HOLD;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              state_q <= flush ? S_DISCARD_D : S_WAIT_DATA;
            end
          end else if (flush) begin
            state_q <= S_DISCARD_A;
          end
        end
        S_WAIT_DATA: begin
          if (inst_data_ok) begin
            if (!flush && s_if) begin
              buf_q   <= inst_rdata;
              state_q <= S_HOLD;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (flush) begin
            state_q <= S_DISCARD_D;
          end
        end
        S_HOLD: begin
          if (flush || !s_if) state_q <= S_IDLE;
        end
        // bus cannot retract a request; finish it silently
        S_DISCARD_A: begin
          if (inst_addr_ok) begin
            req_q   <= 1'b0;
            state_q <= inst_data_ok ? S_IDLE : S_DISCARD_D;
          end
        end
        S_DISCARD_D: begin
          if (inst_data_ok) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  if_id_reg #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .stall_if     (stall[1]),
    .stall_id     (stall[2]),
    .ld           (ld),
    .ld_pc        (ld_pc),
    .ld_inst      (ld_inst),
`ifdef IFETCH_ADEL_EN
    .ld_adel      (adel_ld),
    .id_excp_adel (id_excp_adel),
`endif
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid)
  );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: inputs change at negedge,
// outputs are checked 1 time unit later.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        stallreq_if;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
`ifdef IFETCH_ADEL_EN
  logic        id_excp_adel;
`endif

  int n_chk;
  int n_fail;

  inst_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .ce           (ce),
    .stall        (stall),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .stallreq_if  (stallreq_if),
`ifdef IFETCH_ADEL_EN
    .id_excp_adel (id_excp_adel),
`endif
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    pc = 32'h0;
    ce = 1'b0;
    stall = 6'b0;
    flush = 1'b0;
    inst_addr_ok = 1'b0;
    inst_rdata = 32'h0;
    inst_data_ok = 1'b0;

    // reset values, stallreq gated by reset even with ce=1
    tick();
    ce = 1'b1;
    pc = 32'hBFC00000;
    #1;
    chk("rst_req", inst_req, 0);
    chk("rst_addr", inst_addr, 0);
    chk("rst_idpc", id_pc, 32'hBFC00000);
    chk("rst_inst", id_inst, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_stallreq", stallreq_if, 0);

    // T1: addr_ok in request cycle, data next cycle
    rst = 1'b1;
    #1;
    chk("t1_sr_c0", stallreq_if, 1);
    tick();
    ce = 1'b0;
    inst_addr_ok = 1'b1;
    #1;
    chk("t1_req", inst_req, 1);
    chk("t1_addr", inst_addr, 32'hBFC00000);
    chk("t1_sr_c1", stallreq_if, 1);
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata = 32'h3C080001;
    #1;
    chk("t1_req_drop", inst_req, 0);
    chk("t1_sr_c2", stallreq_if, 0);
    tick();
    inst_data_ok = 1'b0;
    #1;
    chk("t1_inst", id_inst, 32'h3C080001);
    chk("t1_pc", id_pc, 32'hBFC00000);
    chk("t1_valid", id_valid, 1);
    chk("t1_sr_idle", stallreq_if, 0);
    tick();
    #1;
    chk("t1_bub_valid", id_valid, 0);
    chk("t1_bub_inst", id_inst, 0);
    chk("t1_bub_pc", id_pc, 32'hBFC00000);

    // T2: data_ok delayed 5 cycles
    ce = 1'b1;
    pc = 32'hBFC00004;
    tick();
    ce = 1'b0;
    inst_addr_ok = 1'b1;
    #1;
    chk("t2_req", inst_req, 1);
    chk("t2_sr", stallreq_if, 1);
    tick();
    inst_addr_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_wait_sr", stallreq_if, 1);
      chk("t2_wait_req", inst_req, 0);
      chk("t2_wait_valid", id_valid, 0);
      tick();
    end
    inst_data_ok = 1'b1;
    inst_rdata = 32'h24090005;
    #1;
    chk("t2_sr_done", stallreq_if, 0);
    tick();
    inst_data_ok = 1'b0;
    #1;
    chk("t2_inst", id_inst, 32'h24090005);
    chk("t2_pc", id_pc, 32'hBFC00004);
    chk("t2_valid", id_valid, 1);
    tick();
    #1;
    chk("t2_one_load", id_valid, 0);

    // T3: data returns under IF+ID stall -> HOLD
    ce = 1'b1;
    pc = 32'hBFC00008;
    tick();
    ce = 1'b0;
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata = 32'h8D0A0000;
    stall = 6'b000111;
    #1;
    chk("t3_sr_data", stallreq_if, 0);
    tick();
    inst_data_ok = 1'b0;
    #1;
    chk("t3_hold_inst1", id_inst, 0);
    chk("t3_hold_sr", stallreq_if, 0);
    tick();
    #1;
    chk("t3_hold_inst2", id_inst, 0);
    tick();
    stall = 6'b0;
    #1;
    chk("t3_hold_inst3", id_inst, 0);
    chk("t3_hold_pc", id_pc, 32'hBFC00004);
    tick();
    #1;
    chk("t3_inst", id_inst, 32'h8D0A0000);
    chk("t3_pc", id_pc, 32'hBFC00008);
    chk("t3_valid", id_valid, 1);

    // T4: flush in WAIT_DATA, word dropped
    ce = 1'b1;
    pc = 32'hBFC00010;
    tick();
    ce = 1'b0;
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    flush = 1'b1;
    #1;
    chk("t4_sr_flush", stallreq_if, 1);
    tick();
    flush = 1'b0;
    #1;
    chk("t4_fl_valid", id_valid, 0);
    chk("t4_fl_inst", id_inst, 0);
    chk("t4_disc_sr", stallreq_if, 1);
    tick();
    inst_data_ok = 1'b1;
    inst_rdata = 32'h12345678;
    tick();
    inst_data_ok = 1'b0;
    ce = 1'b1;
    pc = 32'hBFC00380;
    #1;
    chk("t4_dropped", id_inst, 0);
    chk("t4_drop_valid", id_valid, 0);
    chk("t4_next_sr", stallreq_if, 1);
    tick();
    ce = 1'b0;
    inst_addr_ok = 1'b1;
    #1;
    chk("t4_next_addr", inst_addr, 32'hBFC00380);
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata = 32'hAC0B0004;
    tick();
    inst_data_ok = 1'b0;
    #1;
    chk("t4_next_inst", id_inst, 32'hAC0B0004);
    chk("t4_next_pc", id_pc, 32'hBFC00380);
    chk("t4_next_valid", id_valid, 1);

    // T5: flush in WAIT_ADDR, addr_ok withheld 2 cycles
    ce = 1'b1;
    pc = 32'hBFC00020;
    tick();
    ce = 1'b0;
    flush = 1'b1;
    #1;
    chk("t5_req_c1", inst_req, 1);
    tick();
    flush = 1'b0;
    #1;
    chk("t5_req_c2", inst_req, 1);
    chk("t5_sr_c2", stallreq_if, 1);
    tick();
    inst_addr_ok = 1'b1;
    #1;
    chk("t5_req_c3", inst_req, 1);
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata = 32'hDEADBEEF;
    #1;
    chk("t5_req_drop", inst_req, 0);
    chk("t5_sr_discd", stallreq_if, 1);
    tick();
    inst_data_ok = 1'b0;
    #1;
    chk("t5_valid", id_valid, 0);
    chk("t5_inst", id_inst, 0);
    chk("t5_sr_idle", stallreq_if, 0);

    // T6: async reset mid-transaction, late data_ok ignored
    ce = 1'b1;
    pc = 32'hBFC00030;
    tick();
    ce = 1'b0;
    #1;
    chk("t6_req", inst_req, 1);
    rst = 1'b0;
    #1;
    chk("t6_req_rst", inst_req, 0);
    chk("t6_pc_rst", id_pc, 32'hBFC00000);
    tick();
    rst = 1'b1;
    inst_data_ok = 1'b1;
    inst_rdata = 32'h11111111;
    tick();
    inst_data_ok = 1'b0;
    #1;
    chk("t6_valid", id_valid, 0);
    chk("t6_inst", id_inst, 0);
    chk("t6_req_idle", inst_req, 0);

`ifdef IFETCH_ADEL_EN
    // T7: misaligned pc traps without a bus request
    ce = 1'b1;
    pc = 32'hBFC00002;
    #1;
    chk("t7_sr", stallreq_if, 0);
    tick();
    ce = 1'b0;
    #1;
    chk("t7_req", inst_req, 0);
    chk("t7_adel", id_excp_adel, 1);
    chk("t7_pc", id_pc, 32'hBFC00002);
    chk("t7_valid", id_valid, 1);
    tick();
    #1;
    chk("t7_adel_clr", id_excp_adel, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
